// File: rtl/fir_sample_feeder.sv
// Sample FIFO and issue sequencer ahead of the serial FIR filter: buffers
// samples, issues one input_valid pulse at a time, and has a completion watchdog.
module fir_sample_feeder #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  fir_data,
  output logic              fir_valid,
  input  logic              fir_done,
  output logic              busy,
  output logic [ADDR_W:0]   level,
  output logic [7:0]        drop_cnt,
  output logic              timeout_flag
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      WDOG_LIMIT = 8'(TIMEOUT);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  fir_data_q;
  logic [7:0]        wdog_q, wdog_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              timeout_q, timeout_d;
  logic              push, pop, drop, expire;

  // Readiness comes from the registered level, so a same-cycle pop never frees a slot.
  assign s_ready = (level_q != LEVEL_FULL);
  assign push    = s_valid && s_ready;
  assign drop    = s_valid && !s_ready;
  assign pop     = (state_q == ST_IDLE) && (level_q != '0);

  assign fir_data     = fir_data_q;
  assign fir_valid    = (state_q == ST_ISSUE);
  assign busy         = (state_q != ST_IDLE);
  assign level        = level_q;
  assign drop_cnt     = drop_cnt_q;
  assign timeout_flag = timeout_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    expire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        wdog_d  = '0;
      end
      ST_WAIT: begin
        if (fir_done) begin
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
          if (wdog_q + 8'd1 == WDOG_LIMIT) begin
            state_d = ST_IDLE;
            expire  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A drop or expiry in the clearing cycle is still recorded.
    drop_cnt_d = drop_cnt_q;
    if (clr_flags) begin
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    timeout_d = expire || (timeout_q && !clr_flags);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wdog_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      timeout_q  <= 1'b0;
      fir_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      timeout_q  <= timeout_d;
      if (pop) begin
        fir_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder: issue latency, fill/drop, ordering,
// watchdog timeout, ignored completions and asynchronous reset.
module tb_fir_sample_feeder;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [WIDTH-1:0]  s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              clr_flags = 1'b0;
  logic [WIDTH-1:0]  fir_data;
  logic              fir_valid;
  logic              fir_done = 1'b0;
  logic              busy;
  logic [ADDR_W:0]   level;
  logic [7:0]        drop_cnt;
  logic              timeout_flag;

  int n_tests = 0;
  int n_fail  = 0;

  fir_sample_feeder #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .clr_flags(clr_flags), .fir_data(fir_data), .fir_valid(fir_valid),
    .fir_done(fir_done), .busy(busy), .level(level), .drop_cnt(drop_cnt),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int k = 0; k <= max_cycles; k++) begin
      if (fir_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    tick();
    tick();
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
    n_tests++; if (fir_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_fsm: got valid=%b busy=%b expected 0 0", fir_valid, busy); end
    n_tests++; if (drop_cnt !== 8'd0 || timeout_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got drop=%0d tflag=%b expected 0 0", drop_cnt, timeout_flag); end
    n_tests++; if (fir_data !== 8'h00) begin n_fail++; $display("FAIL reset_fir_data: got %h expected 00", fir_data); end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    s_data = 8'h05; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    n_tests++; if (level !== 5'd1 || fir_valid !== 1'b0) begin n_fail++; $display("FAIL lat_push: got level=%0d valid=%b expected 1 0", level, fir_valid); end
    tick();
    n_tests++; if (fir_valid !== 1'b1 || fir_data !== 8'h05) begin n_fail++; $display("FAIL lat_issue: got valid=%b data=%h expected 1 05", fir_valid, fir_data); end
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL lat_pop_level: got %0d expected 0", level); end
    $display("[TB] issue data=%h", fir_data);
    tick();
    n_tests++; if (fir_valid !== 1'b0 || busy !== 1'b1 || fir_data !== 8'h05) begin n_fail++; $display("FAIL lat_pulse_width: got valid=%b busy=%b data=%h expected 0 1 05", fir_valid, busy, fir_data); end
    repeat (103) tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lat_still_busy: got %b expected 1", busy); end
    fir_done = 1'b1;
    tick();
    fir_done = 1'b0;
    n_tests++; if (busy !== 1'b0 || timeout_flag !== 1'b0) begin n_fail++; $display("FAIL lat_done: got busy=%b tflag=%b expected 0 0", busy, timeout_flag); end
  endtask

  task automatic test_fill_drop();
    s_data = 8'hEE; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    n_tests++; if (busy !== 1'b1 || level !== 5'd0) begin n_fail++; $display("FAIL fill_pre: got busy=%b level=%0d expected 1 0", busy, level); end
    for (int i = 1; i <= 16; i++) begin
      s_data = 8'(i); s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    n_tests++; if (level !== 5'd16 || s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got level=%0d ready=%b expected 16 0", level, s_ready); end
    s_data = 8'h11; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    n_tests++; if (drop_cnt !== 8'd1 || level !== 5'd16) begin n_fail++; $display("FAIL fill_drop: got drop=%0d level=%0d expected 1 16", drop_cnt, level); end
  endtask

  task automatic test_full_pop_same_cycle();
    fir_done = 1'b1;
    tick();
    fir_done = 1'b0;
    n_tests++; if (busy !== 1'b0 || level !== 5'd16 || s_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_pre: got busy=%b level=%0d ready=%b expected 0 16 0", busy, level, s_ready); end
    s_data = 8'h12; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    n_tests++; if (level !== 5'd15 || drop_cnt !== 8'd2) begin n_fail++; $display("FAIL fullpop_level: got level=%0d drop=%0d expected 15 2", level, drop_cnt); end
    n_tests++; if (fir_valid !== 1'b1 || fir_data !== 8'h01) begin n_fail++; $display("FAIL fullpop_issue: got valid=%b data=%h expected 1 01", fir_valid, fir_data); end
  endtask

  task automatic test_in_order_issue();
    bit ok;
    int seen;
    for (int i = 1; i <= 16; i++) begin
      wait_valid(8, ok);
      n_tests++;
      if (!ok || fir_data !== 8'(i)) begin
        n_fail++;
        $display("FAIL order_%0d: got valid=%b data=%h expected 1 %h", i, ok, fir_data, 8'(i));
      end
      $display("[TB] issue data=%h", fir_data);
      tick();
      fir_done = 1'b1;
      tick();
      fir_done = 1'b0;
    end
    seen = 0;
    repeat (6) begin
      tick();
      if (fir_valid === 1'b1) seen++;
    end
    n_tests++; if (seen != 0 || level !== 5'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL order_drained: got extra=%0d level=%0d busy=%b expected 0 0 0", seen, level, busy); end
  endtask

  task automatic test_timeout();
    bit ok;
    s_data = 8'h7F; s_valid = 1'b1;
    tick();
    s_data = 8'h33;
    tick();
    s_valid = 1'b0;
    wait_valid(4, ok);
    n_tests++; if (!ok || fir_data !== 8'h7F) begin n_fail++; $display("FAIL to_issue: got valid=%b data=%h expected 1 7f", ok, fir_data); end
    $display("[TB] issue data=%h", fir_data);
    repeat (255) tick();
    n_tests++; if (busy !== 1'b1 || timeout_flag !== 1'b0) begin n_fail++; $display("FAIL to_before: got busy=%b tflag=%b expected 1 0", busy, timeout_flag); end
    tick();
    n_tests++; if (busy !== 1'b0 || timeout_flag !== 1'b1) begin n_fail++; $display("FAIL to_expire: got busy=%b tflag=%b expected 0 1", busy, timeout_flag); end
    tick();
    n_tests++; if (fir_valid !== 1'b1 || fir_data !== 8'h33) begin n_fail++; $display("FAIL to_next: got valid=%b data=%h expected 1 33", fir_valid, fir_data); end
    $display("[TB] issue data=%h", fir_data);
    tick();
    fir_done = 1'b1;
    tick();
    fir_done = 1'b0;
    n_tests++; if (timeout_flag !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL to_sticky: got tflag=%b busy=%b expected 1 0", timeout_flag, busy); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    n_tests++; if (timeout_flag !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL to_clear: got tflag=%b drop=%0d expected 0 0", timeout_flag, drop_cnt); end
  endtask

  task automatic test_done_ignored();
    fir_done = 1'b1;
    tick();
    tick();
    n_tests++; if (busy !== 1'b0 || level !== 5'd0 || fir_valid !== 1'b0) begin n_fail++; $display("FAIL ign_idle: got busy=%b level=%0d valid=%b expected 0 0 0", busy, level, fir_valid); end
    fir_done = 1'b0;
    s_data = 8'h44; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    n_tests++; if (fir_valid !== 1'b1 || fir_data !== 8'h44) begin n_fail++; $display("FAIL ign_issue: got valid=%b data=%h expected 1 44", fir_valid, fir_data); end
    fir_done = 1'b1;
    tick();
    fir_done = 1'b0;
    n_tests++; if (busy !== 1'b1 || fir_valid !== 1'b0) begin n_fail++; $display("FAIL ign_in_issue: got busy=%b valid=%b expected 1 0", busy, fir_valid); end
    tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_wait: got busy=%b expected 1", busy); end
    fir_done = 1'b1;
    tick();
    fir_done = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_complete: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      s_data = 8'(8'h10 + i); s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    n_tests++; if (level !== 5'd5 || busy !== 1'b1 || fir_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre: got level=%0d busy=%b valid=%b expected 5 1 0", level, busy, fir_valid); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (fir_valid !== 1'b0 || busy !== 1'b0 || level !== 5'd0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_async: got valid=%b busy=%b level=%0d ready=%b expected 0 0 0 1", fir_valid, busy, level, s_ready); end
    tick();
    rst = 1'b0;
    s_data = 8'hA5; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    n_tests++; if (fir_valid !== 1'b1 || fir_data !== 8'hA5) begin n_fail++; $display("FAIL rstmid_fresh: got valid=%b data=%h expected 1 a5", fir_valid, fir_data); end
    $display("[TB] issue data=%h", fir_data);
    #2 rst = 1'b1;
    #1;
    n_tests++; if (fir_valid !== 1'b0 || fir_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_issue: got valid=%b data=%h expected 0 00", fir_valid, fir_data); end
    tick();
    rst = 1'b0;
    tick();
    n_tests++; if (busy !== 1'b0 || level !== 5'd0) begin n_fail++; $display("FAIL rstmid_after: got busy=%b level=%0d expected 0 0", busy, level); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_drop();
    test_full_pop_same_cycle();
    test_in_order_issue();
    test_timeout();
    test_done_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
Upstream stage of the serial 100-tap, 8-bit FIR filter. Buffers incoming 8-bit samples in a small FIFO and issues them to the filter one at a time. Each sample is issued as a single-cycle input_valid pulse, and the next sample is issued only after the filter's output_valid for the previous one has returned. A watchdog recovers from a filter that never completes, and sticky flags report dropped samples and timeouts.

Parameters:
WIDTH, 8, sample width (matches filter input width)
DEPTH, 16, FIFO entries (power of two)
ADDR_W, 4, log2(DEPTH)
TIMEOUT, 255, max cycles to wait for fir_done before abandoning a sample (≥ filter latency, 8 bits)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
s_data  in  WIDTH  incoming sample
s_valid  in  1  s_data valid this cycle
s_ready  out  1  FIFO can accept (not full)
clr_flags  in  1  synchronous clear of drop_cnt and timeout_flag
fir_data  out  WIDTH  sample presented to filter FIR_input
fir_valid  out  1  one-cycle pulse to filter input_valid
fir_done  in  1  filter output_valid
busy  out  1  a sample is issued and not yet completed
level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
drop_cnt  out  8  saturating count of samples dropped while full
timeout_flag  out  1  sticky: watchdog expired at least once

Behaviour:
- Reset (async, rst=1): FIFO empty, level=0, s_ready=1, fir_data=0, fir_valid=0, busy=0, drop_cnt=0, timeout_flag=0, FSM=IDLE, watchdog=0.
- Push: on a clock edge with s_valid&&s_ready, write s_data at the write pointer; pointer wraps DEPTH-1→0.
- s_ready = (level != DEPTH), combinational from registered level.
- Drop: s_valid && !s_ready drops the sample; drop_cnt increments, saturating at 255.
- FSM states:
  - IDLE: if level≠0, pop the head into the fir_data register and go to ISSUE.
  - ISSUE: fir_valid=1 for exactly this cycle; go to WAIT with watchdog=0.
  - WAIT: fir_valid=0, fir_data held stable.
    - fir_done=1 → IDLE.
    - Otherwise watchdog increments. Reaching TIMEOUT → IDLE, timeout_flag=1, sample abandoned (no retry).
- fir_done is honoured only in WAIT; in IDLE or ISSUE it is ignored with no side effect.
- busy = (state != IDLE).
- Latency: sample pushed at edge k into an empty FIFO with FSM in IDLE → popped at edge k+1 → fir_valid high between edges k+1 and k+2.
- Throughput: one issue per (filter latency + 2) cycles. Back-to-back: fir_done seen at edge j → IDLE; next pop at edge j+1; fir_valid again in cycle j+1..j+2.
- Simultaneous push and pop in one cycle: both occur, level unchanged. When full, the push is refused even if a pop occurs the same cycle (s_ready from registered level).
- level updates by +1 (push only), −1 (pop only), 0 (both or neither). It never exceeds DEPTH and never underflows.
- clr_flags=1: drop_cnt=0, timeout_flag=0 at the next edge. A same-cycle drop or timeout event takes priority (drop_cnt=1 / flag=1).
- Reset mid-operation: FIFO contents discarded and FSM returns to IDLE immediately. An in-flight fir_valid is deasserted asynchronously.
- fir_data changes only on pop; it holds its last value in IDLE.

Test Plan:
- Reset, then push 0x05 at edge 1 → fir_valid pulse exactly one cycle after edge 2 with fir_data=0x05. fir_done pulse 104 cycles later → busy falls at the next edge.
- Push 0x01..0x10 on consecutive cycles, fir_done held low → level reaches 16 and s_ready=0. A 17th push (0x11) is dropped, drop_cnt=1. Return fir_done → samples issued in order 0x01..0x10, 0x11 never issued.
- Full FIFO with an IDLE pop and s_valid in the same cycle → s_ready=0, push refused, level 16→15, drop_cnt increments.
- Issue 0x7F, never assert fir_done → after TIMEOUT=255 WAIT cycles FSM returns to IDLE, timeout_flag=1, and the next queued sample issues. clr_flags → flag 0.
- fir_done pulsed while IDLE and during the ISSUE cycle → no state change, level unchanged, busy unaffected.
- Assert rst in WAIT with level=5 → immediately fir_valid=0, busy=0, level=0, s_ready=1. After release, a fresh push of 0xA5 issues normally.
